// File: rtl/pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for the five-stage ARM pipeline
// (IF, ID, EX, MEM, WB).
//
// Responsibilities:
//   - Startup drain. After reset it forces NOP bubbles into ID/EX for
//     STARTUP_CYCLES cycles.
//   - Load-use stall. It holds the PC and IF/ID for one cycle and inserts a
//     bubble.
//   - Taken-branch flush. It clears IF/ID and then bubbles the squashed slot.
//   - Operand forwarding selects for the three ID register operands.
//
// Parameters:
//   STARTUP_CYCLES  bubble cycles after reset release (1..15)
//   REG_W           register-specifier width
//
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   ID_rn/rm/rd, ID_use_*        ID operand specifiers and their read flags
//   ID_B_taken                   branch in ID resolved taken
//   EX/MEM/WB_rd, *_RF_enable    destination and write flag per stage
//   EX_load_instr                EX holds a load
//   PC_enable, IF_ID_enable      front-end enables
//   IF_ID_flush                  clear IF/ID on the next edge
//   select                       1 = decoded control, 0 = NOP bubble
//   fwd_A/B/C                    00 RF, 01 EX, 10 MEM, 11 WB
//   stall_active                 FSM is in STALL (debug)
//
// Optional feature, enabled by defining HAZARD_PERF_COUNTERS_EN:
//   stall_count, flush_count     saturating 16-bit counts of STALL and
//                                FLUSH entries
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned STARTUP_CYCLES = 4,
  parameter int unsigned REG_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rn,
  input  logic [REG_W-1:0] ID_rm,
  input  logic [REG_W-1:0] ID_rd,
  input  logic             ID_use_rn,
  input  logic             ID_use_rm,
  input  logic             ID_use_rd,
  input  logic             ID_B_taken,
  input  logic [REG_W-1:0] EX_rd,
  input  logic [REG_W-1:0] MEM_rd,
  input  logic [REG_W-1:0] WB_rd,
  input  logic             EX_RF_enable,
  input  logic             MEM_RF_enable,
  input  logic             WB_RF_enable,
  input  logic             EX_load_instr,
  output logic             PC_enable,
  output logic             IF_ID_enable,
  output logic             IF_ID_flush,
  output logic             select,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic [1:0]       fwd_C,
  output logic             stall_active
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count
`endif
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] STARTUP_LAST = 4'(STARTUP_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] startup_cnt;
  logic       load_use;

  // The forwarding priority is EX > MEM > WB. The all-ones specifier is the PC,
  // so it is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic             use_op,
    input logic [REG_W-1:0] spec,
    input logic [REG_W-1:0] ex_d,
    input logic [REG_W-1:0] mem_d,
    input logic [REG_W-1:0] wb_d,
    input logic             ex_en,
    input logic             mem_en,
    input logic             wb_en
  );
    if (!use_op || spec == '1) return 2'b00;
    if (ex_en && ex_d == spec) return 2'b01;
    if (mem_en && mem_d == spec) return 2'b10;
    if (wb_en && wb_d == spec) return 2'b11;
    return 2'b00;
  endfunction

  // The load-use hazard means EX holds a load whose destination is read in ID.
  always_comb begin
    load_use = 1'b0;
    if (EX_load_instr && EX_RF_enable) begin
      if (ID_use_rn && ID_rn == EX_rd) load_use = 1'b1;
      if (ID_use_rm && ID_rm == EX_rd) load_use = 1'b1;
      if (ID_use_rd && ID_rd == EX_rd) load_use = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  // The counter only advances during the startup drain. It holds afterwards
  // until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      startup_cnt <= '0;
    else if (state == S_INIT && startup_cnt != STARTUP_LAST)
      startup_cnt <= startup_cnt + 4'd1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  state_next = (startup_cnt == STARTUP_LAST) ? S_RUN : S_INIT;
      S_RUN: begin
        if (load_use)        state_next = S_STALL;
        else if (ID_B_taken) state_next = S_FLUSH;
        else                 state_next = S_RUN;
      end
      // The stalled load has moved to MEM and EX now holds a bubble, so no
      // load-use check happens here.
      S_STALL: state_next = ID_B_taken ? S_FLUSH : S_RUN;
      S_FLUSH: state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  // Reset gates the outputs combinationally, so they drop on the asynchronous
  // assertion and do not wait for the state register to settle.
  always_comb begin
    PC_enable    = 1'b0;
    IF_ID_enable = 1'b0;
    IF_ID_flush  = 1'b0;
    select       = 1'b0;
    stall_active = 1'b0;
    fwd_A        = 2'b00;
    fwd_B        = 2'b00;
    fwd_C        = 2'b00;
    if (!reset) begin
      if (state != S_INIT) begin
        fwd_A = fwd_sel(ID_use_rn, ID_rn, EX_rd, MEM_rd, WB_rd,
                        EX_RF_enable, MEM_RF_enable, WB_RF_enable);
        fwd_B = fwd_sel(ID_use_rm, ID_rm, EX_rd, MEM_rd, WB_rd,
                        EX_RF_enable, MEM_RF_enable, WB_RF_enable);
        fwd_C = fwd_sel(ID_use_rd, ID_rd, EX_rd, MEM_rd, WB_rd,
                        EX_RF_enable, MEM_RF_enable, WB_RF_enable);
      end
      case (state)
        S_INIT: begin
          PC_enable    = 1'b1;
          IF_ID_enable = 1'b1;
        end
        S_RUN, S_STALL: begin
          stall_active = (state == S_STALL);
          if (state == S_RUN && load_use) begin
            PC_enable    = 1'b0;
            IF_ID_enable = 1'b0;
          end else begin
            PC_enable    = 1'b1;
            IF_ID_enable = 1'b1;
            select       = 1'b1;
            IF_ID_flush  = ID_B_taken;
          end
        end
        S_FLUSH: begin
          PC_enable    = 1'b1;
          IF_ID_enable = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  // Each count increments on the edge that enters its state and saturates
  // at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (state_next == S_STALL && state != S_STALL && stall_count != '1)
        stall_count <= stall_count + 16'd1;
      if (state_next == S_FLUSH && state != S_FLUSH && flush_count != '1)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int STARTUP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ID_rn, ID_rm, ID_rd, EX_rd, MEM_rd, WB_rd;
  logic       ID_use_rn, ID_use_rm, ID_use_rd, ID_B_taken;
  logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr;
  logic       PC_enable, IF_ID_enable, IF_ID_flush, select, stall_active;
  logic [1:0] fwd_A, fwd_B, fwd_C;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [15:0] stall_count, flush_count;
`endif

  pipeline_hazard_ctrl #(.STARTUP_CYCLES(STARTUP), .REG_W(4)) dut (
    .clk(clk), .reset(reset),
    .ID_rn(ID_rn), .ID_rm(ID_rm), .ID_rd(ID_rd),
    .ID_use_rn(ID_use_rn), .ID_use_rm(ID_use_rm), .ID_use_rd(ID_use_rd),
    .ID_B_taken(ID_B_taken),
    .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable),
    .WB_RF_enable(WB_RF_enable), .EX_load_instr(EX_load_instr),
    .PC_enable(PC_enable), .IF_ID_enable(IF_ID_enable),
    .IF_ID_flush(IF_ID_flush), .select(select),
    .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_C(fwd_C),
    .stall_active(stall_active)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It tracks how many startup cycles remain and whether the
  // previous edge began a stall or a flush.
  int init_left   = STARTUP;
  bit after_stall = 1'b0;
  bit after_flush = 1'b0;
  int m_stalls    = 0;
  int m_flushes   = 0;

  function automatic bit model_load_use();
    return EX_load_instr && EX_RF_enable &&
           ((ID_use_rn && ID_rn == EX_rd) || (ID_use_rm && ID_rm == EX_rd) ||
            (ID_use_rd && ID_rd == EX_rd));
  endfunction

  function automatic bit lu_now();
    return !after_stall && model_load_use();
  endfunction

  function automatic int model_fwd(input logic use_op, input logic [3:0] spec);
    logic [3:0] rds [3];
    logic       ens [3];
    rds = '{EX_rd, MEM_rd, WB_rd};
    ens = '{EX_RF_enable, MEM_RF_enable, WB_RF_enable};
    if (!use_op || spec == 4'd15) return 0;
    for (int k = 0; k < 3; k++)
      if (ens[k] && rds[k] == spec) return k + 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      init_left   <= STARTUP;
      after_stall <= 1'b0;
      after_flush <= 1'b0;
      m_stalls    <= 0;
      m_flushes   <= 0;
    end else if (init_left > 0) begin
      init_left <= init_left - 1;
    end else if (after_flush) begin
      after_flush <= 1'b0;
    end else begin
      after_stall <= lu_now();
      after_flush <= !lu_now() && ID_B_taken;
      if (lu_now() && m_stalls < 65535) m_stalls <= m_stalls + 1;
      if (!lu_now() && ID_B_taken && m_flushes < 65535) m_flushes <= m_flushes + 1;
    end
  end

  task automatic compare_outputs();
    int e_pc, e_ifid, e_flush, e_sel, e_stall, e_fa, e_fb, e_fc;
    e_pc = 0; e_ifid = 0; e_flush = 0; e_sel = 0; e_stall = 0;
    e_fa = 0; e_fb = 0; e_fc = 0;
    if (!reset) begin
      if (init_left > 0) begin
        e_pc = 1; e_ifid = 1;
      end else begin
        e_fa = model_fwd(ID_use_rn, ID_rn);
        e_fb = model_fwd(ID_use_rm, ID_rm);
        e_fc = model_fwd(ID_use_rd, ID_rd);
        if (after_flush) begin
          e_pc = 1; e_ifid = 1;
        end else begin
          e_stall = after_stall ? 1 : 0;
          if (!lu_now()) begin
            e_pc = 1; e_ifid = 1; e_sel = 1;
            e_flush = ID_B_taken ? 1 : 0;
          end
        end
      end
    end
    check("m_PC_enable", PC_enable, e_pc);
    check("m_IF_ID_enable", IF_ID_enable, e_ifid);
    check("m_IF_ID_flush", IF_ID_flush, e_flush);
    check("m_select", select, e_sel);
    check("m_stall_active", stall_active, e_stall);
    check("m_fwd_A", fwd_A, e_fa);
    check("m_fwd_B", fwd_B, e_fb);
    check("m_fwd_C", fwd_C, e_fc);
`ifdef HAZARD_PERF_COUNTERS_EN
    check("m_stall_count", stall_count, reset ? 0 : m_stalls);
    check("m_flush_count", flush_count, reset ? 0 : m_flushes);
`endif
  endtask

  always @(negedge clk) compare_outputs();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rn = 4'd0; ID_rm = 4'd0; ID_rd = 4'd0;
    ID_use_rn = 1'b0; ID_use_rm = 1'b0; ID_use_rd = 1'b0; ID_B_taken = 1'b0;
    EX_rd = 4'd0; MEM_rd = 4'd0; WB_rd = 4'd0;
    EX_RF_enable = 1'b0; MEM_RF_enable = 1'b0; WB_RF_enable = 1'b0;
    EX_load_instr = 1'b0;
  endtask

  task automatic set_load_use();
    EX_load_instr = 1'b1; EX_rd = 4'd5; EX_RF_enable = 1'b1;
    ID_rm = 4'd5; ID_use_rm = 1'b1;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    clear_inputs();
    #1;
    check("rst_PC_enable", PC_enable, 0);
    check("rst_select", select, 0);
    check("rst_stall", stall_active, 0);
    #2 reset = 1'b0;

    // Startup drain. Hazards and a branch are presented and must be ignored.
    ID_rn = 4'd3; ID_use_rn = 1'b1; EX_rd = 4'd3; EX_RF_enable = 1'b1;
    EX_load_instr = 1'b1; ID_B_taken = 1'b1;
    #1;
    check("init0_select", select, 0);
    check("init0_pc", PC_enable, 1);
    check("init0_fwd_A", fwd_A, 0);
    check("init0_flush", IF_ID_flush, 0);
    for (int i = 1; i < STARTUP; i++) begin
      tick();
      if (i == STARTUP - 1) clear_inputs();
      #2;
      check("init_select", select, 0);
      check("init_pc", PC_enable, 1);
    end

    // Forwarding priority.
    tick();
    ID_rn = 4'd3; ID_use_rn = 1'b1; EX_rd = 4'd3; MEM_rd = 4'd3; WB_rd = 4'd3;
    EX_RF_enable = 1'b1; MEM_RF_enable = 1'b1; WB_RF_enable = 1'b1;
    #2;
    check("run_select", select, 1);
    check("fwd_ex", fwd_A, 1);
    tick(); EX_RF_enable = 1'b0; #2; check("fwd_mem", fwd_A, 2);
    tick(); MEM_RF_enable = 1'b0; #2; check("fwd_wb", fwd_A, 3);
    tick(); ID_rn = 4'd15; #2; check("fwd_pc15", fwd_A, 0);

    // Load-use stall.
    tick(); clear_inputs(); set_load_use(); #2;
    check("lu_pc", PC_enable, 0);
    check("lu_ifid", IF_ID_enable, 0);
    check("lu_select", select, 0);
    tick();
    EX_load_instr = 1'b0; EX_RF_enable = 1'b0; MEM_rd = 4'd5; MEM_RF_enable = 1'b1;
    #2;
    check("stall_active", stall_active, 1);
    check("stall_fwd_B", fwd_B, 2);
    tick(); clear_inputs(); #2;
    check("post_stall_stall", stall_active, 0);
    check("post_stall_pc", PC_enable, 1);
    check("post_stall_select", select, 1);

    // Branch flush.
    tick(); ID_B_taken = 1'b1; #2;
    check("br_flush", IF_ID_flush, 1);
    check("br_select", select, 1);
    tick(); ID_B_taken = 1'b0; #2;
    check("flush_select", select, 0);
    check("flush_flush", IF_ID_flush, 0);
    tick(); #2; check("after_flush_select", select, 1);

    // Load-use and a branch arrive together. The branch is held through the stall.
    tick(); set_load_use(); ID_B_taken = 1'b1; #2;
    check("lu_br_flush", IF_ID_flush, 0);
    check("lu_br_pc", PC_enable, 0);
    tick(); EX_load_instr = 1'b0; #2;
    check("lu_br_stall", stall_active, 1);
    check("lu_br_stall_flush", IF_ID_flush, 1);
    tick(); clear_inputs(); #2;
    check("lu_br_flushstate_select", select, 0);
    check("lu_br_flushstate_stall", stall_active, 0);
    tick(); #2; check("lu_br_run_select", select, 1);

    // Reset asserted in the middle of a stall.
    tick(); set_load_use(); #2;
    tick(); clear_inputs(); #2;
    check("pre_rst_stall", stall_active, 1);
`ifdef HAZARD_PERF_COUNTERS_EN
    check("pre_rst_stall_count", stall_count, 3);
    check("pre_rst_flush_count", flush_count, 2);
`endif
    #1 reset = 1'b1;
    #1;
    check("midrst_pc", PC_enable, 0);
    check("midrst_ifid", IF_ID_enable, 0);
    check("midrst_stall", stall_active, 0);
    check("midrst_select", select, 0);
`ifdef HAZARD_PERF_COUNTERS_EN
    check("midrst_stall_count", stall_count, 0);
`endif
    #1 reset = 1'b0;
    for (int i = 0; i < STARTUP; i++) begin
      tick(); #2;
      check("restart_select", select, (i == STARTUP - 1) ? 1 : 0);
      check("restart_pc", PC_enable, 1);
    end

    // Randomized traffic, with occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      tick();
      ID_rn = rnd_reg(); ID_rm = rnd_reg(); ID_rd = rnd_reg();
      EX_rd = rnd_reg(); MEM_rd = rnd_reg(); WB_rd = rnd_reg();
      ID_use_rn = 1'($urandom_range(0, 1));
      ID_use_rm = 1'($urandom_range(0, 1));
      ID_use_rd = 1'($urandom_range(0, 1));
      EX_RF_enable  = 1'($urandom_range(0, 1));
      MEM_RF_enable = 1'($urandom_range(0, 1));
      WB_RF_enable  = 1'($urandom_range(0, 1));
      EX_load_instr = ($urandom_range(0, 2) == 0);
      ID_B_taken    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
